// File: rtl/api_slave_mc.sv
// api_slave_mc -- multi-channel Wishbone register slave for CH_NUM API engines.
//
// Decodes LM32 Wishbone accesses into per-channel TX push / RX pop / flush
// strobes and muxes per-channel status back onto the bus. The FIFOs and shift
// engines live outside; this block only decodes, strobes and muxes.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   API_*                 Wishbone slave (CYC/LOCK/CTI/BTE/SEL unused, RTY = 0)
//   txfifo_push/din       one-hot push strobe, shared push data
//   txfull, txcnt         per-channel TX status (packed)
//   rxfifo_pop            one-hot pop strobe
//   rxfifo_dout, rxempty, rxcnt, reg_state   per-channel RX/engine status
//   flush                 per-channel flush pulse, FLUSH_LEN cycles long
//   reg_timeout/sck/ch_num/word_num          shared engine configuration
//   irq                   registered level interrupt, |(status & mask)
//
// Optional: define API_TRAM_EN to map a 512x32 test ROM (api_tram) at 0x1C:
// write sets the ROM address, read returns ROM data.

// Per-channel flush counter: loads FLUSH_LEN, counts down, flush while nonzero.
module api_slave_mc_flush #(
  parameter int FLUSH_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic flush
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)             cnt <= '0;
    else if (load)       cnt <= 4'(FLUSH_LEN);
    else if (cnt != '0)  cnt <= cnt - 4'd1;

  assign flush = (cnt != '0);
endmodule

`ifdef API_TRAM_EN
// 512x32 synchronous test ROM with registered output.
module api_tram (
  input  logic        clk,
  input  logic [8:0]  addr,
  output logic [31:0] q
);
  logic [31:0] mem [512];

  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always_ff @(posedge clk) q <= mem[addr];
endmodule
`endif

module api_slave_mc #(
  parameter int CH_NUM    = 4,
  parameter int CH_W      = 2,
  parameter int RXCNT_W   = 10,
  parameter int TXCNT_W   = 11,
  parameter int FLUSH_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      API_CYC_I,
  input  logic                      API_STB_I,
  input  logic                      API_WE_I,
  input  logic                      API_LOCK_I,
  input  logic [2:0]                API_CTI_I,
  input  logic [1:0]                API_BTE_I,
  input  logic [3:0]                API_SEL_I,
  input  logic [5:0]                API_ADR_I,
  input  logic [31:0]               API_DAT_I,
  output logic                      API_ACK_O,
  output logic                      API_ERR_O,
  output logic                      API_RTY_O,
  output logic [31:0]               API_DAT_O,
  output logic [CH_NUM-1:0]         txfifo_push,
  output logic [31:0]               txfifo_din,
  input  logic [CH_NUM-1:0]         txfull,
  input  logic [CH_NUM*TXCNT_W-1:0] txcnt,
  output logic [CH_NUM-1:0]         rxfifo_pop,
  input  logic [CH_NUM*32-1:0]      rxfifo_dout,
  input  logic [CH_NUM-1:0]         rxempty,
  input  logic [CH_NUM*RXCNT_W-1:0] rxcnt,
  input  logic [CH_NUM*3-1:0]       reg_state,
  output logic [CH_NUM-1:0]         flush,
  output logic [27:0]               reg_timeout,
  output logic [7:0]                reg_sck,
  output logic [5:0]                reg_ch_num,
  output logic [7:0]                reg_word_num,
  output logic                      irq
);
  localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h1, A_STATE = 4'h2, A_TMO = 4'h3,
                         A_SCK = 4'h4, A_CHSEL = 4'h5, A_IRQ = 4'h6, A_TRAM = 4'h7;

  logic              acc;
  logic [3:0]        adr;
  logic [CH_W-1:0]   sel;
  logic [CH_NUM-1:0] irq_stat, irq_mask, rxempty_q;
  logic [CH_NUM-1:0] push_n, pop_n, flush_ld, irq_set, irq_clr;
  logic              err_n;
  logic [31:0]       rd_data, rx_dout_sel;
  logic [10:0]       txcnt_z;
  logic [9:0]        rxcnt_z;
  logic [2:0]        state_sel;
  logic              unused_ok;

  // ACK/ERR are one-cycle pulses, so gating on them gives one access per 2 cycles.
  assign acc       = API_STB_I & ~API_ACK_O & ~API_ERR_O;
  assign adr       = API_ADR_I[5:2];
  assign API_RTY_O = 1'b0;
  assign unused_ok = ^{API_CYC_I, API_LOCK_I, API_CTI_I, API_BTE_I, API_SEL_I, API_ADR_I[1:0]};

  assign rx_dout_sel = rxfifo_dout[32'(sel)*32 +: 32];
  assign txcnt_z     = 11'(txcnt[32'(sel)*TXCNT_W +: TXCNT_W]);
  assign rxcnt_z     = 10'(rxcnt[32'(sel)*RXCNT_W +: RXCNT_W]);
  assign state_sel   = reg_state[32'(sel)*3 +: 3];

`ifdef API_TRAM_EN
  logic [8:0]  tram_addr;
  logic [31:0] tram_q;

  api_tram u_tram (.clk(clk), .addr(tram_addr), .q(tram_q));

  always_ff @(posedge clk or posedge rst)
    if (rst)                                      tram_addr <= '0;
    else if (acc && API_WE_I && adr == A_TRAM)    tram_addr <= API_DAT_I[8:0];
`endif

  // Access decode: read mux, strobes and error response.
  always_comb begin
    rd_data  = 32'hDEADDEAD;
    push_n   = '0;
    pop_n    = '0;
    flush_ld = '0;
    irq_clr  = '0;
    err_n    = 1'b0;
    if (acc) begin
      case (adr)
        A_TX:
          if (API_WE_I) begin
            if (txfull[sel]) err_n = 1'b1;
            else             push_n[sel] = 1'b1;
          end
        A_RX:
          if (!rxempty[sel]) begin
            rd_data = rx_dout_sel;
            if (!API_WE_I) pop_n[sel] = 1'b1;
          end else begin
            rd_data = 32'h12345678;
          end
        A_STATE: begin
          rd_data = {2'b0, rxcnt_z, 3'b0, rxempty[sel], state_sel, txcnt_z,
                     flush[sel], txfull[sel]};
          if (API_WE_I && API_DAT_I[1]) flush_ld[sel] = 1'b1;
        end
        A_TMO:   rd_data = {4'b0, reg_timeout};
        A_SCK:   rd_data = {reg_word_num, 2'b0, reg_ch_num, 8'b0, reg_sck};
        A_CHSEL: rd_data = 32'(sel);
        A_IRQ: begin
          rd_data = {16'(irq_mask), 16'(irq_stat)};
          if (API_WE_I) irq_clr = API_DAT_I[CH_NUM-1:0];
        end
`ifdef API_TRAM_EN
        A_TRAM:  rd_data = tram_q;
`endif
        default: rd_data = 32'hDEADDEAD;
      endcase
    end
  end

  // Falling edge of rxempty: data just arrived in that channel's RX FIFO.
  assign irq_set = rxempty_q & ~rxempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      API_ACK_O    <= 1'b0;
      API_ERR_O    <= 1'b0;
      API_DAT_O    <= '0;
      txfifo_push  <= '0;
      txfifo_din   <= '0;
      rxfifo_pop   <= '0;
      sel          <= '0;
      reg_timeout  <= '0;
      reg_sck      <= '0;
      reg_ch_num   <= '0;
      reg_word_num <= '0;
      irq_stat     <= '0;
      irq_mask     <= '0;
      rxempty_q    <= '0;
      irq          <= 1'b0;
    end else begin
      API_ACK_O   <= acc & ~err_n;
      API_ERR_O   <= acc & err_n;
      API_DAT_O   <= (acc && !API_WE_I) ? rd_data : '0;
      txfifo_push <= push_n;
      rxfifo_pop  <= pop_n;
      if (push_n != '0) txfifo_din <= API_DAT_I;
      if (acc && API_WE_I) begin
        case (adr)
          A_TMO: reg_timeout <= API_DAT_I[27:0];
          A_SCK: begin
            reg_word_num <= API_DAT_I[31:24];
            reg_ch_num   <= API_DAT_I[21:16];
            reg_sck      <= API_DAT_I[7:0];
          end
          A_CHSEL: if (API_DAT_I < 32'(CH_NUM)) sel <= API_DAT_I[CH_W-1:0];
          A_IRQ:   irq_mask <= API_DAT_I[16 +: CH_NUM];
          default: ;
        endcase
      end
      rxempty_q <= rxempty;
      // A new edge in the same cycle as a W1C clear must not be lost.
      irq_stat  <= (irq_stat & ~irq_clr) | irq_set;
      irq       <= |(irq_stat & irq_mask);
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    api_slave_mc_flush #(.FLUSH_LEN(FLUSH_LEN)) u_flush (
      .clk(clk), .rst(rst), .load(flush_ld[n]), .flush(flush[n])
    );
  end
endmodule

// File: tb/tb_api_slave_mc.sv
module tb_api_slave_mc;
  logic        clk = 0, rst = 1;
  logic        stb = 0, we = 0;
  logic [5:0]  adr = 0;
  logic [31:0] wdat = 0;
  logic        ack, err, rty;
  logic [31:0] rdat, din;
  logic [3:0]  push, pop, flush;
  logic [3:0]  txfull = 0, rxempty = 0;
  logic [43:0] txcnt = 0;
  logic [39:0] rxcnt = 0;
  logic [127:0] dout = 0;
  logic [11:0] rstate = 0;
  logic [27:0] tmo;
  logic [7:0]  sck, wnum;
  logic [5:0]  cnum;
  logic        irq;

  int n_chk = 0, n_err = 0, fl_cnt = 0;

  typedef struct {
    logic ack; logic err; logic rd; logic [31:0] dat; logic [3:0] push; logic [3:0] pop;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(negedge clk) if (flush[3]) fl_cnt <= fl_cnt + 1;

  api_slave_mc dut (
    .clk(clk), .rst(rst), .API_CYC_I(stb), .API_STB_I(stb), .API_WE_I(we),
    .API_LOCK_I(1'b0), .API_CTI_I(3'b0), .API_BTE_I(2'b0), .API_SEL_I(4'hF),
    .API_ADR_I(adr), .API_DAT_I(wdat), .API_ACK_O(ack), .API_ERR_O(err),
    .API_RTY_O(rty), .API_DAT_O(rdat), .txfifo_push(push), .txfifo_din(din),
    .txfull(txfull), .txcnt(txcnt), .rxfifo_pop(pop), .rxfifo_dout(dout),
    .rxempty(rxempty), .rxcnt(rxcnt), .reg_state(rstate), .flush(flush),
    .reg_timeout(tmo), .reg_sck(sck), .reg_ch_num(cnum), .reg_word_num(wnum), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ACK/ERR is visible.
  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee,
                     input logic [3:0] ep, input logic [3:0] eo);
    exp_t e;
    logic got = 0;
    sb.push_back('{ack: !ee, err: ee, rd: !w, dat: ed, push: ep, pop: eo});
    stb = 1; we = w; adr = a; wdat = wd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack || err) begin got = 1; break; end
    end
    stb = 0; we = 0;
    e = sb.pop_front();
    if (!got) chk($sformatf("timeout@%02h", a), 32'(ack | err), 32'd1);
    else begin
      chk($sformatf("ack@%02h", a), 32'(ack), 32'(e.ack));
      chk($sformatf("err@%02h", a), 32'(err), 32'(e.err));
      if (e.rd) chk($sformatf("dat@%02h", a), rdat, e.dat);
      chk($sformatf("push@%02h", a), 32'(push), 32'(e.push));
      chk($sformatf("pop@%02h", a), 32'(pop), 32'(e.pop));
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus(1, a, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] ed);
    bus(0, a, 0, ed, 0, 0, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dat", rdat, 0);
    chk("rst_strb", {push, pop, flush}, 0);
    chk("rst_din", din, 0);
    chk("rst_cfg", {tmo, sck, cnum, wnum}, 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;
    @(negedge clk);

    // Register reads after reset (all inputs for channel 0 are zero).
    rd(6'h08, 0); rd(6'h0C, 0); rd(6'h10, 0); rd(6'h14, 0); rd(6'h18, 0);
    chk("rty", 32'(rty), 0);
    rxempty = 4'hF;
    @(negedge clk);

    // Config registers, reserved bits read back as 0.
    wr(6'h0C, 32'hFFFF_FFFF); rd(6'h0C, 32'h0FFF_FFFF);
    chk("tmo_out", 32'(tmo), 32'h0FFF_FFFF);
    wr(6'h10, 32'hFFFF_FFFF); rd(6'h10, 32'hFF3F_00FF);
    chk("sck_out", {wnum, 2'b0, cnum, sck}, 32'hFF3F_FF);
    wr(6'h10, 32'h1200_0034); rd(6'h10, 32'h1200_0034);

    // STATE packing for channel 1.
    wr(6'h14, 1); rd(6'h14, 1);
    txcnt[11 +: 11] = 11'h5A3; rxcnt[10 +: 10] = 10'h2C1; rstate[3 +: 3] = 3'b101;
    txfull[1] = 1;
    rd(6'h08, 32'h2C11_B68D);
    txcnt = 0; rxcnt = 0; rstate = 0; txfull = 0;

    // CHSEL: out-of-range ignored, max value accepted.
    wr(6'h14, 7); rd(6'h14, 1);
    wr(6'h14, 3); rd(6'h14, 3);

    // TX push / overflow error on channel 2.
    wr(6'h14, 2);
    txfull = 4'b1011;
    bus(1, 6'h00, 32'hA5A5_A5A5, 0, 0, 4'b0100, 0);
    chk("tx_din", din, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("push_1cyc", 32'(push), 0);
    chk("ack_1cyc", 32'(ack), 0);
    txfull = 4'b0100;
    bus(1, 6'h00, 32'h5A5A_5A5A, 0, 1, 0, 0);
    txfull = 0;
    rd(6'h00, 32'hDEAD_DEAD);

    // RX pop / empty on channel 1.
    wr(6'h14, 1);
    dout = {32'hCAFE_0003, 32'hCAFE_0002, 32'h1122_3344, 32'hCAFE_0000};
    rxempty[1] = 0;
    bus(0, 6'h04, 0, 32'h1122_3344, 0, 0, 4'b0010);
    rxempty[1] = 1;
    rd(6'h04, 32'h1234_5678);
    wr(6'h04, 32'hFFFF_FFFF);

    // Unmapped addresses.
    rd(6'h1C, 32'hDEAD_DEAD); rd(6'h3C, 32'hDEAD_DEAD); wr(6'h3C, 32'h1);

    // Flush on channel 3: single, no-op write, reload.
    wr(6'h14, 3);
    base = fl_cnt;
    wr(6'h08, 32'h2);
    chk("flush_onehot", 32'(flush), 32'b1000);
    repeat (12) @(negedge clk);
    chk("flush_len", fl_cnt - base, 4);
    base = fl_cnt;
    wr(6'h08, 32'h1);
    repeat (8) @(negedge clk);
    chk("flush_nop", fl_cnt - base, 0);
    base = fl_cnt;
    wr(6'h08, 32'h2);
    wr(6'h08, 32'h2);
    repeat (12) @(negedge clk);
    chk("flush_reload", fl_cnt - base, 6);

    // IRQ: clear stale status, mask channel 0.
    wr(6'h18, 32'h0001_FFFF);
    rd(6'h18, 32'h0001_0000);
    @(negedge clk);
    chk("irq_idle", 32'(irq), 0);
    rxempty[0] = 0;
    @(negedge clk);
    chk("irq_t1", 32'(irq), 0);
    @(negedge clk);
    chk("irq_t2", 32'(irq), 1);
    rd(6'h18, 32'h0001_0001);
    wr(6'h18, 32'h0001_0001);
    @(negedge clk);
    chk("irq_clr", 32'(irq), 0);
    rd(6'h18, 32'h0001_0000);
    rxempty[0] = 1;
    repeat (2) @(negedge clk);
    rxempty[0] = 0;
    wr(6'h18, 32'h0001_0001);
    rd(6'h18, 32'h0001_0001);
    chk("irq_setwins", 32'(irq), 1);
    wr(6'h18, 32'h0001_0001);
    repeat (2) @(negedge clk);
    rxempty[2] = 0;
    repeat (3) @(negedge clk);
    chk("irq_masked", 32'(irq), 0);
    rd(6'h18, 32'h0001_0004);

    // Reset in the middle of a flush.
    wr(6'h08, 32'h2);
    chk("flush_on", 32'(flush), 32'b1000);
    #2 rst = 1;
    #1;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_ack2", 32'(ack), 0);
    @(negedge clk);
    chk("rst_tmo", 32'(tmo), 0);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("post_rst", {flush, push, pop}, 0);
    rd(6'h14, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
